// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial stimulus path that feeds the
// sequence-detector FSM.
package seq_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam int SEQ_W = 16;

endpackage : seq_pkg

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage: accepts a word over a load handshake and presents
// it one bit per accepted cycle over a valid/ready bit handshake.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_W,
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             last,
    output logic             done,
    output logic [CNT_W-1:0] bit_idx
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic             load_fire;
    logic             bit_fire;

    // Presentation outputs come only from registers, so bit_ready never
    // reaches bit_out combinationally.
    assign bit_valid = (state == S_SHIFT);
    assign bit_out   = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
    assign last      = bit_valid && (bit_idx == LAST_IDX);

    assign bit_fire   = bit_valid && bit_ready;
    assign load_ready = (state == S_IDLE) || (bit_fire && last);
    assign load_fire  = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first, so every path assigns state_nxt and no latch
        // is inferred.
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (load_valid) state_nxt = S_SHIFT;
            S_SHIFT: if (bit_fire && last) state_nxt = load_valid ? S_SHIFT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            bit_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= bit_fire && last;
            // A reload on the final accepted bit takes priority over shifting,
            // which gives back-to-back words with no bubble.
            if (load_fire) begin
                shift_reg <= load_data;
                bit_idx   <= '0;
            end else if (bit_fire && !last) begin
                shift_reg <= LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
                bit_idx   <= bit_idx + CNT_W'(1);
            end
        end
    end

endmodule : seq_serializer

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: LSB/MSB order, stall, back-to-back,
// mid-word reset and ignored loads.
module tb_seq_serializer;

    localparam int W  = 16;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_valid = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic          bit_ready = 1'b1;

    logic          load_ready, bit_out, bit_valid, last, done;
    logic [CW-1:0] bit_idx;
    logic          m_load_ready, m_bit_out, m_bit_valid, m_last, m_done;
    logic [CW-1:0] m_bit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // 16'h5772 emitted LSB first and MSB first, written out by hand.
    logic exp_lsb [16] = '{0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0};
    logic exp_msb [16] = '{0,1,0,1,0,1,1,1,0,1,1,1,0,0,1,0};

    seq_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .last(last), .done(done), .bit_idx(bit_idx)
    );

    seq_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_ready(m_load_ready),
        .bit_out(m_bit_out), .bit_valid(m_bit_valid), .bit_ready(bit_ready),
        .last(m_last), .done(m_done), .bit_idx(m_bit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and land 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_word(input logic [W-1:0] word);
        load_valid = 1'b1;
        load_data  = word;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        int cyc;

        // Reset state
        #2;
        check("rst_load_ready", load_ready, 1);
        check("rst_bit_valid",  bit_valid,  0);
        check("rst_bit_out",    bit_out,    0);
        check("rst_last",       last,       0);
        check("rst_done",       done,       0);
        check("rst_bit_idx",    bit_idx,    0);
        step();
        rst = 1'b1;
        step();

        // 16'h5772, free-running, both bit orders
        start_word(16'h5772);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("lsb_bit%0d", i),  bit_out,    exp_lsb[i]);
            check($sformatf("msb_bit%0d", i),  m_bit_out,  exp_msb[i]);
            check($sformatf("valid%0d", i),    bit_valid,  1);
            check($sformatf("idx%0d", i),      bit_idx,    i);
            check($sformatf("last%0d", i),     last,       (i == 15));
            check($sformatf("m_last%0d", i),   m_last,     (i == 15));
            check($sformatf("lready%0d", i),   load_ready, (i == 15));
            check($sformatf("nodone%0d", i),   done,       0);
            step();
        end
        check("done_pulse",      done,       1);
        check("m_done_pulse",    m_done,     1);
        check("idle_valid",      bit_valid,  0);
        check("idle_load_ready", load_ready, 1);
        step();
        check("done_one_cycle",  done,       0);

        // Stall of 3 cycles at bit 5
        start_word(16'h5772);
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                bit_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    cyc++;
                    check("stall_out",   bit_out,   1);
                    check("stall_idx",   bit_idx,   5);
                    check("stall_valid", bit_valid, 1);
                    check("stall_done",  done,      0);
                end
                bit_ready = 1'b1;
            end
            check($sformatf("stall_seq%0d", i), bit_out, exp_lsb[i]);
            step();
            cyc++;
        end
        check("stall_done_pulse", done, 1);
        check("stall_latency",    cyc,  19);
        step();

        // Back-to-back 16'hFFFF then 16'h0000 with load_valid held
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        step();
        load_data  = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            if (i == 16) load_valid = 1'b0;
            check($sformatf("b2b_valid%0d", i), bit_valid, 1);
            check($sformatf("b2b_bit%0d", i),   bit_out,   (i < 16));
            check($sformatf("b2b_idx%0d", i),   bit_idx,   i % 16);
            check($sformatf("b2b_done%0d", i),  done,      (i == 16));
            step();
        end
        check("b2b_done2",     done,      1);
        check("b2b_end_valid", bit_valid, 0);
        step();

        // Asynchronous reset mid-word at bit 7
        start_word(16'h5772);
        repeat (7) step();
        check("pre_rst_idx", bit_idx, 7);
        #2 rst = 1'b0;
        #1;
        check("async_valid", bit_valid,  0);
        check("async_out",   bit_out,    0);
        check("async_last",  last,       0);
        check("async_idx",   bit_idx,    0);
        check("async_ready", load_ready, 1);
        step();
        check("rst_no_done", done, 0);
        rst = 1'b1;
        step();
        check("post_rst_done",  done,       0);
        check("post_rst_ready", load_ready, 1);
        start_word(16'h0001);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("one_bit%0d", i), bit_out, (i == 0));
            step();
        end
        check("one_done", done, 1);
        step();

        // Load attempt at bit 3 is ignored
        start_word(16'h5772);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                load_valid = 1'b1;
                load_data  = 16'hAAAA;
                check("ign_load_ready", load_ready, 0);
            end else begin
                load_valid = 1'b0;
            end
            check($sformatf("ign_bit%0d", i), bit_out, exp_lsb[i]);
            step();
        end
        check("ign_done",  done,      1);
        check("ign_idle",  bit_valid, 0);
        step();
        check("ign_idle2", bit_valid, 0);
        check("ign_nodone", done,     0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_serializer
